decode416_seq: RTL and testbench

//   Registered 4-to-16 one-hot decoder; the inverse of the CPU's 16-to-4 encoder.

---
 rtl/cpu_defs.sv | 15 +
 rtl/onehot416.sv | 12 +
 rtl/decode416_seq.sv | 132 +++++++++++++
 tb/tb_decode416_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Widths and state encodings shared by the one-hot decoder and the CPU's 16-to-4 encoder.
package cpu_defs;

    localparam int SEL_W    = 4;
    localparam int ONEHOT_W = 16;

    localparam logic [SEL_W-1:0] LAST_IDX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/onehot416.sv
// Pure combinational 4-to-16 decode. The shift is done at the full 16-bit width,
// so every 4-bit index produces exactly one set bit.
module onehot416
    import cpu_defs::*;
(
    input  logic [SEL_W-1:0]    sel,
    output logic [ONEHOT_W-1:0] onehot
);

    assign onehot = ONEHOT_W'(1) << sel;

endmodule

// File: rtl/decode416_seq.sv
// Registered 4-to-16 one-hot decoder with a valid/ready index input and a
// bring-up sweep that walks the one-hot bit from 0x0001 to 0x8000.
//
// state    | meaning
// ST_IDLE  | accepting indices; a decode completes here without leaving the state
// ST_SWEEP | walking index 0..15, each held STEP_CYCLES cycles
// ST_DONE  | one-cycle sweep_done pulse, out cleared, then back to idle
module decode416_seq
    import cpu_defs::*;
#(
    parameter int STEP_CYCLES = 1,
    parameter bit HOLD        = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [SEL_W-1:0]    in_sel,
    output logic                in_ready,
    input  logic                sweep_start,
    output logic [ONEHOT_W-1:0] out,
    output logic                out_valid,
    output logic                busy,
    output logic                sweep_done
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);

    state_t                state;
    logic [STEP_W-1:0]     step_cnt;
    logic [SEL_W-1:0]      idx;
    logic [ONEHOT_W-1:0]   out_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic                  busy_r;
    logic                  sweep_done_r;

    logic                  accept;
    logic [SEL_W-1:0]      idx_next;
    logic [SEL_W-1:0]      dec_sel;
    logic [ONEHOT_W-1:0]   dec_out;

    // in_ready_r is high exactly in ST_IDLE, so it doubles as the accept qualifier.
    assign accept   = in_valid && in_ready_r;

    // Outside a sweep idx_next is 0, which is the first sweep step on a start.
    assign idx_next = (state == ST_SWEEP) ? idx + SEL_W'(1) : '0;
    assign dec_sel  = accept ? in_sel : idx_next;

    onehot416 u_onehot (
        .sel    (dec_sel),
        .onehot (dec_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            step_cnt     <= '0;
            idx          <= '0;
            out_r        <= '0;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sweep_done_r <= 1'b0;
                    if (accept) begin
                        out_r       <= dec_out;
                        out_valid_r <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b0;
                        if (sweep_start) begin
                            state      <= ST_SWEEP;
                            busy_r     <= 1'b1;
                            in_ready_r <= 1'b0;
                            idx        <= '0;
                            step_cnt   <= STEP_LOAD;
                            out_r      <= dec_out;
                        end else if (!HOLD) begin
                            out_r <= '0;
                        end
                    end
                end

                ST_SWEEP: begin
                    out_valid_r <= 1'b0;
                    if (step_cnt == '0) begin
                        if (idx == LAST_IDX) begin
                            state        <= ST_DONE;
                            busy_r       <= 1'b0;
                            sweep_done_r <= 1'b1;
                            out_r        <= '0;
                        end else begin
                            idx      <= idx_next;
                            step_cnt <= STEP_LOAD;
                            out_r    <= dec_out;
                        end
                    end else begin
                        step_cnt <= step_cnt - STEP_W'(1);
                    end
                end

                ST_DONE: begin
                    state        <= ST_IDLE;
                    sweep_done_r <= 1'b0;
                    in_ready_r   <= 1'b1;
                    idx          <= '0;
                end

                default: begin
                    state        <= ST_IDLE;
                    out_r        <= '0;
                    out_valid_r  <= 1'b0;
                    in_ready_r   <= 1'b1;
                    busy_r       <= 1'b0;
                    sweep_done_r <= 1'b0;
                end
            endcase
        end
    end

    // en only masks the ports; the handshake and sweep keep running underneath.
    assign out        = en ? out_r : '0;
    assign out_valid  = en & out_valid_r;
    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;

endmodule

// File: tb/tb_decode416_seq.sv
// Directed bench for decode416_seq: a main instance (STEP_CYCLES=2, HOLD=1) and a
// second instance (STEP_CYCLES=1, HOLD=0) sharing the same stimulus.
module tb_decode416_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [3:0]  in_sel;
    logic        sweep_start;

    logic [15:0] out0, out1;
    logic        out_valid0, out_valid1;
    logic        in_ready0, in_ready1;
    logic        busy0, busy1;
    logic        sweep_done0, sweep_done1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decode416_seq #(.STEP_CYCLES(2), .HOLD(1'b1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready0), .sweep_start(sweep_start), .out(out0),
        .out_valid(out_valid0), .busy(busy0), .sweep_done(sweep_done0)
    );

    decode416_seq #(.STEP_CYCLES(1), .HOLD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready1), .sweep_start(sweep_start), .out(out1),
        .out_valid(out_valid1), .busy(busy1), .sweep_done(sweep_done1)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  sel;
        logic        sw;
        logic        en;
        logic [15:0] eo;
        logic        ev;
        logic        er;
        logic        eb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] eo, input logic ev,
                           input logic er, input logic eb, input logic ed);
        chk({tag, ".out"},        {16'h0, out0},        {16'h0, eo});
        chk({tag, ".out_valid"},  {31'h0, out_valid0},  {31'h0, ev});
        chk({tag, ".in_ready"},   {31'h0, in_ready0},   {31'h0, er});
        chk({tag, ".busy"},       {31'h0, busy0},       {31'h0, eb});
        chk({tag, ".sweep_done"}, {31'h0, sweep_done0}, {31'h0, ed});
    endtask

    // Reference 16-to-4 encoder: highest set bit, 0 for an all-zero input.
    function automatic logic [3:0] enc16(input logic [15:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    initial begin
        logic [15:0] e;

        vecs[0]  = '{1'b1, 4'hA, 1'b0, 1'b1, 16'h0400, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h0400, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h0400, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'h5, 1'b0, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'h3, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sel = 4'h0; sweep_start = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_all("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // HOLD=0 instance clears one cycle after a decode; HOLD=1 keeps it.
        in_valid = 1'b1; in_sel = 4'h6;
        step();
        chk("hold0.out_set",   {16'h0, out1}, 32'h0040);
        chk("hold0.out_valid", {31'h0, out_valid1}, 32'h1);
        in_valid = 1'b0;
        step();
        chk("hold0.out_clear", {16'h0, out1}, 32'h0000);
        chk("hold1.out_kept",  {16'h0, out0}, 32'h0040);

        for (int i = 0; i < 12; i++) begin
            in_valid    = vecs[i].iv;
            in_sel      = vecs[i].sel;
            sweep_start = vecs[i].sw;
            en          = vecs[i].en;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ev, vecs[i].er, vecs[i].eb, 1'b0);
            if (vecs[i].ev)
                chk($sformatf("vec%0d.roundtrip", i), {28'h0, enc16(out0)}, {28'h0, vecs[i].sel});
        end
        in_valid = 1'b0; sweep_start = 1'b0; en = 1'b1;

        // Full sweep, STEP_CYCLES=2; in_valid held throughout, stray sweep_start ignored.
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        in_valid = 1'b1; in_sel = 4'h9;
        for (int k = 0; k < 32; k++) begin
            e = 16'h0001 << (k / 2);
            chk_all($sformatf("sweep%0d", k), e, 1'b0, 1'b0, 1'b1, 1'b0);
            sweep_start = (k == 10);
            step();
        end
        sweep_start = 1'b1;
        chk_all("sweep_done", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        sweep_start = 1'b0;
        chk_all("after_sweep", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("held_accept", 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;

        // Reset mid-sweep at index 7.
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int k = 0; k < 14; k++) step();
        chk("sweep_idx7", {16'h0, out0}, 32'h0080);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("midsweep_reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("post_reset_idle", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // STEP_CYCLES=1 sweep: 16 single-cycle steps then DONE.
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = 16'h0001 << i;
            chk($sformatf("step1_sweep%0d", i), {15'h0, busy1, out1}, {15'h0, 1'b1, e});
            step();
        end
        chk("step1_done", {15'h0, sweep_done1, out1}, {15'h0, 1'b1, 16'h0000});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
